// File: rtl/ev2_pcie_packer.sv
// ev2 16-bit word stream -> 32-bit valid/ready beats, with FWFT FIFO, pad timeout and ev2 reset/ack handshake.
// Optional beat/pad statistics counters are built when EV2_PACK_STATS_EN is defined.
module ev2_pcie_packer #(
    parameter int          DEPTH_LOG2  = 9,
    parameter int          PAD_TIMEOUT = 255,
    parameter logic [15:0] PAD_WORD    = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] ev2_dat_i,
    input  logic        ev2_wr_i,
    output logic        ev2_full_o,
    output logic [15:0] ev2_count_o,
    input  logic        ev2_rst_i,
    output logic        ev2_rst_ack_o,
    output logic [31:0] m_dat_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        overflow_o,
    output logic [1:0]  dbg_state_o
`ifdef EV2_PACK_STATS_EN
    ,
    output logic [31:0] beats_o,
    output logic [15:0] pads_o
`endif
);
    // Handshake: a beat transfers on a rising edge where m_valid_o && m_ready_i;
    // m_dat_o/m_valid_o never change while m_valid_o && !m_ready_i (except when flushed).
    localparam int          AW      = DEPTH_LOG2;
    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [31:0] CNT_CAP = 32'(2 * (DEPTH - 1));
    localparam logic [15:0] CNT_RST = (CNT_CAP > 32'h0000_FFFF) ? 16'hFFFF : CNT_CAP[15:0];
    localparam logic [7:0]  PAD_LAST = 8'(PAD_TIMEOUT - 1);

    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_FLUSH = 2'd1, ST_ACK = 2'd2} state_t;
    state_t state_q, state_d;

    logic [31:0]  mem [DEPTH];
    logic [AW:0]  wptr_q, rptr_q, mem_cnt;
    logic [AW+1:0] occ;
    logic         run, flush, mem_full, mem_empty;
    logic         out_valid_q, pend_q, ovf_q;
    logic [31:0]  out_dat_q;
    logic [15:0]  half_q, count_q;
    logic [7:0]   pad_cnt_q;
    logic         wr_acc, pair_push, pad_due, pad_push, push, pop, accept;
    logic [31:0]  push_dat, used_w, free_w;
    logic [15:0]  count_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (ev2_rst_i) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_ACK;
            ST_ACK:   if (!ev2_rst_i) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    assign run       = (state_q == ST_RUN);
    assign flush     = (state_q == ST_FLUSH);
    assign mem_cnt   = wptr_q - rptr_q;
    assign mem_full  = (mem_cnt == (AW+1)'(DEPTH));
    assign mem_empty = (mem_cnt == '0);
    assign occ       = {1'b0, mem_cnt} + (AW+2)'(out_valid_q);

    // Full one entry early so a half-completed pair always has a slot to land in.
    assign ev2_full_o    = !run || (occ >= (AW+2)'(DEPTH - 1));
    assign ev2_count_o   = run ? count_q : 16'h0000;
    assign ev2_rst_ack_o = (state_q == ST_ACK);
    assign m_valid_o     = out_valid_q && run;
    assign m_dat_o       = out_dat_q;
    assign overflow_o    = ovf_q;
    assign dbg_state_o   = state_q;

    assign wr_acc    = run && ev2_wr_i && !ev2_full_o;
    assign pair_push = wr_acc && pend_q;
    assign pad_due   = run && pend_q && !wr_acc && (pad_cnt_q == PAD_LAST);
    assign pad_push  = pad_due && !mem_full;
    assign push      = pair_push || pad_push;
    assign push_dat  = pair_push ? {ev2_dat_i, half_q} : {PAD_WORD, half_q};
    assign accept    = m_valid_o && m_ready_i;
    assign pop       = !mem_empty && (!out_valid_q || accept);

    always_comb begin
        used_w = 32'({occ, 1'b0}) + 32'(pend_q);
        free_w = (used_w >= CNT_CAP) ? 32'd0 : (CNT_CAP - used_w);
        count_d = (free_w > 32'h0000_FFFF) ? 16'hFFFF : free_w[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q[AW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
            pend_q      <= 1'b0;
            half_q      <= '0;
            pad_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            count_q     <= CNT_RST;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wptr_q      <= '0;
                rptr_q      <= '0;
                out_valid_q <= 1'b0;
                out_dat_q   <= '0;
                pend_q      <= 1'b0;
                pad_cnt_q   <= '0;
                ovf_q       <= 1'b0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop) begin
                    rptr_q      <= rptr_q + 1'b1;
                    out_valid_q <= 1'b1;
                    out_dat_q   <= mem[rptr_q[AW-1:0]];
                end else if (accept) begin
                    out_valid_q <= 1'b0;
                end
                if (wr_acc) begin
                    pend_q <= !pend_q;
                    if (!pend_q) half_q <= ev2_dat_i;
                end else if (pad_push) begin
                    pend_q <= 1'b0;
                end
                // Counter saturates at the expiry value so a blocked pad fires as soon as room appears.
                if (wr_acc || !pend_q || pad_push) pad_cnt_q <= '0;
                else if (pad_cnt_q != PAD_LAST)    pad_cnt_q <= pad_cnt_q + 8'd1;
                if (run && ev2_wr_i && ev2_full_o) ovf_q <= 1'b1;
            end
        end
    end

`ifdef EV2_PACK_STATS_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beats_o <= '0;
            pads_o  <= '0;
        end else if (flush) begin
            beats_o <= '0;
            pads_o  <= '0;
        end else begin
            if (accept)   beats_o <= beats_o + 32'd1;
            if (pad_push) pads_o  <= pads_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ev2_pcie_packer.sv
// Scoreboarded bench for ev2_pcie_packer: pairing, pad timeout, full/overflow, reset handshake, random backpressure.
module tb_ev2_pcie_packer;
    localparam int DEPTH = 512;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [15:0] ev2_dat_i;
    logic        ev2_wr_i;
    logic        ev2_full_o;
    logic [15:0] ev2_count_o;
    logic        ev2_rst_i;
    logic        ev2_rst_ack_o;
    logic [31:0] m_dat_o;
    logic        m_valid_o;
    logic        m_ready_i;
    logic        overflow_o;
    logic [1:0]  dbg_state_o;
`ifdef EV2_PACK_STATS_EN
    logic [31:0] beats_o;
    logic [15:0] pads_o;
`endif

    ev2_pcie_packer dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ev2_dat_i(ev2_dat_i), .ev2_wr_i(ev2_wr_i),
        .ev2_full_o(ev2_full_o), .ev2_count_o(ev2_count_o),
        .ev2_rst_i(ev2_rst_i), .ev2_rst_ack_o(ev2_rst_ack_o),
        .m_dat_o(m_dat_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .overflow_o(overflow_o), .dbg_state_o(dbg_state_o)
`ifdef EV2_PACK_STATS_EN
        , .beats_o(beats_o), .pads_o(pads_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          beats_seen = 0;
    bit          rand_rdy = 1'b0;
    bit          stab_en = 1'b1;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [15:0] d);
        @(posedge clk_i);
        #1;
        ev2_wr_i  = w;
        ev2_dat_i = d;
        if (rand_rdy) m_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [15:0] d);
        int t;
        t = 0;
        cyc(1'b0, 16'h0000);
        while (ev2_full_o && t < 2000) begin
            cyc(1'b0, 16'h0000);
            t++;
        end
        if (t >= 2000) chk("send_timeout", 32'(t), 32'd0);
        ev2_wr_i  = 1'b1;
        ev2_dat_i = d;
    endtask

    task automatic wait_drain(input int bound);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            cyc(1'b0, 16'h0000);
            t++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) cyc(1'b0, 16'h0000);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i && stab_en && prev_stall) begin
                chk("hold_valid", 32'(m_valid_o), 32'd1);
                chk("hold_dat", m_dat_o, prev_dat);
            end
            if (m_valid_o && m_ready_i) begin
                beats_seen++;
                chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_dat_o, e);
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_dat   = m_dat_o;
        end
    end

    initial begin
        logic [15:0] d, prev;
        int          snap;
        rst_n_i   = 1'b0;
        ev2_dat_i = '0;
        ev2_wr_i  = 1'b0;
        ev2_rst_i = 1'b0;
        m_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_full", 32'(ev2_full_o), 32'd0);
        chk("rst_count", 32'(ev2_count_o), 32'(2 * DEPTH - 2));
        chk("rst_ack", 32'(ev2_rst_ack_o), 32'd0);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_dat", m_dat_o, 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        repeat (2) cyc(1'b0, 16'h0000);

        // Basic pair and latency
        snap = beats_seen;
        cyc(1'b1, 16'h1111);
        cyc(1'b1, 16'h2222);
        exp_q.push_back(32'h2222_1111);
        cyc(1'b0, 16'h0000);
        chk("lat_n1_valid", 32'(m_valid_o), 32'd0);
        cyc(1'b0, 16'h0000);
        chk("lat_n2_valid", 32'(m_valid_o), 32'd1);
        chk("lat_n2_dat", m_dat_o, 32'h2222_1111);
        wait_drain(50);
        chk("pair_beats", 32'(beats_seen - snap), 32'd1);

        // Pad timeout
        snap = beats_seen;
        cyc(1'b1, 16'hABCD);
        exp_q.push_back(32'h0000_ABCD);
        repeat (3) cyc(1'b0, 16'h0000);
        chk("pend_count", 32'(ev2_count_o), 32'(2 * DEPTH - 3));
        repeat (300) cyc(1'b0, 16'h0000);
        chk("pad_beats", 32'(beats_seen - snap), 32'd1);
        chk("pad_q", 32'(exp_q.size()), 32'd0);
        chk("pad_count", 32'(ev2_count_o), 32'(2 * DEPTH - 2));
`ifdef EV2_PACK_STATS_EN
        chk("pads_o", 32'(pads_o), 32'd1);
`endif

        // Write on the exact expiry cycle wins
        snap = beats_seen;
        cyc(1'b1, 16'h5555);
        repeat (254) cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'h6666);
        exp_q.push_back(32'h6666_5555);
        repeat (300) cyc(1'b0, 16'h0000);
        chk("expiry_beats", 32'(beats_seen - snap), 32'd1);
        chk("expiry_q", 32'(exp_q.size()), 32'd0);

        // Fill with backpressure, overflow, then drain in order
        m_ready_i = 1'b0;
        prev = '0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            d = 16'($urandom_range(0, 65535));
            cyc(1'b1, d);
            chk("full_rise", 32'(ev2_full_o), 32'(i >= 2 * DEPTH - 2));
            if (i == 2 * DEPTH - 2) chk("ovf_before", 32'(overflow_o), 32'd0);
            if ((i % 2 == 1) && (i < 2 * DEPTH - 2)) exp_q.push_back({d, prev});
            prev = d;
        end
        repeat (3) cyc(1'b0, 16'h0000);
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("full_count", 32'(ev2_count_o), 32'd0);
        chk("full_q", 32'(exp_q.size()), 32'(DEPTH - 1));
        #1 m_ready_i = 1'b1;
        wait_drain(3000);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);
        chk("drain_count", 32'(ev2_count_o), 32'(2 * DEPTH - 2));

        // Reset handshake with half-full FIFO and a pending word
        m_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b1, 16'($urandom_range(0, 65535)));
        repeat (4) cyc(1'b0, 16'h0000);
        chk("hs_pre_valid", 32'(m_valid_o), 32'd1);
        stab_en = 1'b0;
        cyc(1'b0, 16'h0000);
        ev2_rst_i = 1'b1;
        @(negedge clk_i);
        chk("hs_c0_ack", 32'(ev2_rst_ack_o), 32'd0);
        cyc(1'b1, 16'h7777);
        chk("hs_c1_ack", 32'(ev2_rst_ack_o), 32'd0);
        chk("hs_c1_valid", 32'(m_valid_o), 32'd0);
        chk("hs_c1_full", 32'(ev2_full_o), 32'd1);
        chk("hs_c1_count", 32'(ev2_count_o), 32'd0);
        cyc(1'b1, 16'h8888);
        chk("hs_c2_ack", 32'(ev2_rst_ack_o), 32'd1);
        chk("hs_c2_ovf", 32'(overflow_o), 32'd0);
        chk("hs_c2_valid", 32'(m_valid_o), 32'd0);
        cyc(1'b0, 16'h0000);
        chk("hs_ack_ovf", 32'(overflow_o), 32'd0);
        ev2_rst_i = 1'b0;
        @(negedge clk_i);
        chk("hs_d0_ack", 32'(ev2_rst_ack_o), 32'd1);
        cyc(1'b0, 16'h0000);
        chk("hs_d1_ack", 32'(ev2_rst_ack_o), 32'd0);
        chk("hs_d1_full", 32'(ev2_full_o), 32'd0);
        chk("hs_d1_count", 32'(ev2_count_o), 32'(2 * DEPTH - 2));
        m_ready_i = 1'b1;
        snap = beats_seen;
        repeat (300) cyc(1'b0, 16'h0000);
        chk("hs_empty", 32'(beats_seen - snap), 32'd0);
        stab_en = 1'b1;

        // Random backpressure stream
        snap = beats_seen;
        rand_rdy = 1'b1;
        prev = '0;
        for (int i = 0; i < 1000; i++) begin
            d = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 16'h0000);
            send(d);
            if (i % 2 == 1) exp_q.push_back({d, prev});
            prev = d;
        end
        wait_drain(5000);
        rand_rdy = 1'b0;
        chk("rand_beats", 32'(beats_seen - snap), 32'd500);
`ifdef EV2_PACK_STATS_EN
        chk("beats_o", beats_o, 32'd500);
        chk("pads_o_end", 32'(pads_o), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ev2_pcie_packer.md
Name: ev2_pcie_packer

Overview:
- Sits between the ev2 event-FIFO write side and the PCIe DMA engine.
- Accepts the 16-bit ev2 word stream (dat/wr/full/count/rst/rst_ack) and buffers it in an internal FIFO.
- Packs word pairs into 32-bit beats and presents them on a valid/ready stream to the PCIe bridge.
- Implements the ev2 reset/acknowledge handshake and flushes an odd trailing word on timeout.

Parameters:
- DEPTH_LOG2, 9, log2 of FIFO depth in 32-bit entries (DEPTH = 2^DEPTH_LOG2).
- PAD_TIMEOUT, 255, idle cycles after which a lone pending half-word is padded and pushed (8-bit counter, 1..255).
- PAD_WORD, 16'h0000, value placed in [31:16] when padding.

Ports:
- clk_i  in  1  single clock (the ev2 irsclk domain); all logic is on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- ev2_dat_i  in  16  ev2 data word.
- ev2_wr_i  in  1  write strobe, one word per high cycle.
- ev2_full_o  out  1  writer must not assert ev2_wr_i while high.
- ev2_count_o  out  16  free space in 16-bit words, saturated at 16'hFFFF.
- ev2_rst_i  in  1  ev2 reset request (level).
- ev2_rst_ack_o  out  1  reset acknowledge (level).
- m_dat_o  out  32  packed beat; first-received word in [15:0].
- m_valid_o  out  1  beat valid.
- m_ready_i  in  1  consumer accepts the beat when m_valid_o && m_ready_i.
- overflow_o  out  1  sticky: a write arrived while full; cleared only by reset or the ev2 reset handshake.

Behaviour:
- Async reset (rst_n_i low) values:
  - FIFO and half-word register empty; state = RUN.
  - ev2_full_o = 0, ev2_count_o = min(2*DEPTH-2, 16'hFFFF), ev2_rst_ack_o = 0.
  - m_valid_o = 0, m_dat_o = 0, overflow_o = 0.
- Packing:
  - First write loads the half register (pending = 1).
  - Second write forms {dat, half} and pushes it into the FIFO on the next edge; pending = 0.
- FIFO: synchronous, DEPTH entries, with a registered output stage in first-word-fall-through style.
- Latency: pair-completing write in cycle N, FIFO and output stage empty -> m_valid_o = 1 in cycle N+2.
- Output handshake:
  - m_dat_o and m_valid_o are held stable while m_valid_o && !m_ready_i.
  - Back-to-back beats are supported, one per cycle.
- Full and count:
  - ev2_full_o = 1 when FIFO occupancy >= DEPTH-1, which guarantees room for a pending pair.
  - ev2_count_o = 2*(DEPTH-1-occupancy) - pending, floored at 0, registered one cycle.
- Overflow: ev2_wr_i while ev2_full_o = 1 -> word dropped, overflow_o set.
- Pad timeout:
  - Counter runs while pending = 1 and no write occurs; any write resets it.
  - At PAD_TIMEOUT, push {PAD_WORD, half} and clear pending.
  - Write in the same cycle as expiry: the write wins and pairs normally, no pad.
  - FIFO at DEPTH (no room) at expiry: hold the pad until room exists.
- Reset handshake, states RUN, FLUSH, ACK:
  - RUN -> FLUSH when ev2_rst_i = 1.
  - FLUSH, one cycle: clear FIFO pointers, pending, output stage and overflow_o.
  - FLUSH -> ACK.
  - ACK: ev2_rst_ack_o = 1 until ev2_rst_i = 0, then -> RUN with ev2_rst_ack_o = 0.
  - In FLUSH and ACK: ev2_full_o = 1, ev2_count_o = 0, writes ignored and not counted as overflow, m_valid_o = 0.
  - A beat being accepted during the FLUSH edge is discarded.
- Pointer wrap: DEPTH_LOG2+1-bit pointers; the MSB distinguishes full from empty.

Optional Feature:
- Macro: EV2_PACK_STATS_EN.
- Defined:
  - Adds outputs beats_o[31:0] (count of accepted m_ beats) and pads_o[15:0] (count of timeout pads).
  - Both wrap modulo 2^width.
  - Both are cleared by async reset and by FLUSH.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then write 16'h1111, 16'h2222 on consecutive cycles with m_ready_i = 1 -> m_valid_o high 2 cycles after the second write, m_dat_o = 32'h2222_1111, a single beat.
- Write a single 16'hABCD and idle 255 cycles -> exactly one beat 32'h0000_ABCD; pads_o = 1 when EV2_PACK_STATS_EN is defined.
- Hold m_ready_i = 0 and write 2*DEPTH words -> ev2_full_o rises at occupancy DEPTH-1, extra writes set overflow_o, then m_ready_i = 1 drains DEPTH-1 beats in order.
- Assert ev2_rst_i with FIFO half full and pending = 1 -> ev2_rst_ack_o rises 2 cycles later; FIFO empty, overflow_o = 0, m_valid_o = 0; ack drops 1 cycle after ev2_rst_i falls.
- Write on the exact timeout expiry cycle -> normal pair {new, half}, no pad beat.
- Toggle m_ready_i randomly while streaming 1000 words -> 500 beats, data in order and unchanged while stalled.
